// File: rtl/wb_port_arbiter.sv
// Two-requester arbiter for the register-file write port: ALU path (0) vs load path (1).
// Optional starvation aging for requester 0 is enabled with `define WB_ARB_AGING_EN.
module wb_port_arbiter #(
  parameter int DATA_W       = 16,
  parameter int ADDR_W       = 3,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              mux_sel,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [7:0]        conflict_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_HOLD} state_t;

  state_t state, state_nxt;
  logic   gnt0, gnt1, xfer, promote;

`ifdef WB_ARB_AGING_EN
  logic [3:0] wait_cnt;

  assign promote = (wait_cnt >= 4'(STARVE_LIMIT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (!req0_valid || gnt0) begin
      wait_cnt <= '0;
    end else if (!stall && wait_cnt != 4'hF) begin
      wait_cnt <= wait_cnt + 4'd1;
    end
  end
`else
  logic unused_starve_limit;

  assign promote             = 1'b0;
  assign unused_starve_limit = (STARVE_LIMIT != 0);
`endif

  // NOTE: every variable driven in always_comb gets a default first so no latch is inferred.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (rst_n && !stall) begin
      if (req0_valid && req1_valid) begin
        gnt0 = promote;
        gnt1 = !promote;
      end else begin
        gnt0 = req0_valid;
        gnt1 = req1_valid;
      end
    end
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign xfer       = gnt0 || gnt1;

  always_comb begin
    state_nxt = S_IDLE;
    if (stall)     state_nxt = S_HOLD;
    else if (xfer) state_nxt = S_WRITE;
  end

  // NOTE: sequential state always uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // NOTE: the data/address registers are reset too, since their reset value is observable on the ports.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mux_sel  <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else if (xfer) begin
      mux_sel  <= gnt1;
      rf_waddr <= gnt1 ? req1_addr : req0_addr;
      rf_wdata <= gnt1 ? req1_data : req0_data;
    end
  end

  // WRITE means a transfer happened on the last edge; writes to register 0 are suppressed.
  assign rf_we = (state == S_WRITE) && (rf_waddr != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conflict_cnt <= '0;
    end else if (req0_valid && req1_valid && !stall && conflict_cnt != 8'hFF) begin
      conflict_cnt <= conflict_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: directed stimulus, a per-cycle reference model
// and literal expectations. Define WB_ARB_AGING_EN for both files to exercise aging.
module tb_wb_port_arbiter;

  localparam int DATA_W       = 16;
  localparam int ADDR_W       = 3;
  localparam int STARVE_LIMIT = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              stall;
  logic              req0_valid, req1_valid;
  logic [ADDR_W-1:0] req0_addr, req1_addr;
  logic [DATA_W-1:0] req0_data, req1_data;
  logic              req0_ready, req1_ready;
  logic              mux_sel, rf_we;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic [7:0]        conflict_cnt;

  int n_checks = 0;
  int n_errors = 0;

  wb_port_arbiter #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
    .mux_sel(mux_sel), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: what the outputs must be, derived from the arbitration rules.
  logic        m_we, m_sel;
  int          m_waddr, m_wdata, m_cnt, m_wait;
  int          g;
  initial begin
    m_we = 0; m_sel = 0; m_waddr = 0; m_wdata = 0; m_cnt = 0; m_wait = 0;
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      m_we = 0; m_sel = 0; m_waddr = 0; m_wdata = 0; m_cnt = 0; m_wait = 0;
    end
    check("m.rf_we", rf_we, m_we);
    check("m.mux_sel", mux_sel, m_sel);
    check("m.rf_waddr", rf_waddr, m_waddr);
    check("m.rf_wdata", rf_wdata, m_wdata);
    check("m.conflict_cnt", conflict_cnt, m_cnt);

    g = -1;
    if (rst_n && !stall) begin
      if (req0_valid && req1_valid) begin
`ifdef WB_ARB_AGING_EN
        g = (m_wait >= STARVE_LIMIT) ? 0 : 1;
`else
        g = 1;
`endif
      end else if (req1_valid) g = 1;
      else if (req0_valid)     g = 0;
    end
    check("m.req0_ready", req0_ready, g == 0);
    check("m.req1_ready", req1_ready, g == 1);

    if (rst_n) begin
      if (g >= 0) begin
        m_sel   = (g == 1);
        m_waddr = (g == 1) ? req1_addr : req0_addr;
        m_wdata = (g == 1) ? req1_data : req0_data;
        m_we    = (m_waddr != 0);
      end else begin
        m_we = 0;
      end
      if (req0_valid && req1_valid && !stall && m_cnt < 255) m_cnt++;
      if (!req0_valid || g == 0)    m_wait = 0;
      else if (!stall && m_wait < 15) m_wait++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 0; stall = 0;
    req0_valid = 0; req0_addr = '0; req0_data = '0;
    req1_valid = 1; req1_addr = 3'd2; req1_data = 16'hBEEF;

    // Reset: readies stay low even with a pending request
    step(); step();
    check("rst.req1_ready", req1_ready, 0);
    check("rst.rf_we", rf_we, 0);
    check("rst.rf_wdata", rf_wdata, 0);
    check("rst.conflict_cnt", conflict_cnt, 0);
    req1_valid = 0;
    rst_n = 1;
    step();

    // Single request from requester 0
    req0_valid = 1; req0_addr = 3'd3; req0_data = 16'h1234;
    #1 check("single.req0_ready", req0_ready, 1);
    step();
    req0_valid = 0;
    check("single.rf_we", rf_we, 1);
    check("single.rf_waddr", rf_waddr, 3);
    check("single.rf_wdata", rf_wdata, 16'h1234);
    check("single.mux_sel", mux_sel, 0);

    // Contention: requester 1 wins, requester 0 follows
    req0_valid = 1; req0_addr = 3'd2; req0_data = 16'hAAAA;
    req1_valid = 1; req1_addr = 3'd5; req1_data = 16'h5555;
    #1 check("cont.req1_ready", req1_ready, 1);
    check("cont.req0_ready", req0_ready, 0);
    step();
    req1_valid = 0;
    check("cont.first_wdata", rf_wdata, 16'h5555);
    check("cont.first_sel", mux_sel, 1);
    check("cont.conflict_cnt", conflict_cnt, 1);
    #1 check("cont.req0_ready2", req0_ready, 1);
    step();
    req0_valid = 0;
    check("cont.second_wdata", rf_wdata, 16'hAAAA);
    check("cont.second_sel", mux_sel, 0);

    // Stall for three cycles with both requests pending
    stall = 1;
    req0_valid = 1; req0_addr = 3'd1; req0_data = 16'h0101;
    req1_valid = 1; req1_addr = 3'd6; req1_data = 16'h0606;
    #1 check("stall.req0_ready", req0_ready, 0);
    check("stall.req1_ready", req1_ready, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall.rf_we", rf_we, 0);
      check("stall.rf_wdata_hold", rf_wdata, 16'hAAAA);
      check("stall.conflict_cnt", conflict_cnt, 1);
    end
    stall = 0;
    #1 check("stall.release_req1", req1_ready, 1);
    step();
    req1_valid = 0;
    check("stall.first_wdata", rf_wdata, 16'h0606);
    check("stall.conflict_cnt2", conflict_cnt, 2);
    step();
    req0_valid = 0;
    check("stall.second_wdata", rf_wdata, 16'h0101);

    // Register zero: accepted, no write enable, data still captured
    req1_valid = 1; req1_addr = 3'd0; req1_data = 16'hFFFF;
    #1 check("r0.req1_ready", req1_ready, 1);
    step();
    req1_valid = 0;
    check("r0.rf_we", rf_we, 0);
    check("r0.rf_wdata", rf_wdata, 16'hFFFF);
    check("r0.mux_sel", mux_sel, 1);

    // Reset right after an acceptance
    req0_valid = 1; req0_addr = 3'd4; req0_data = 16'h4444;
    step();
    req0_valid = 0;
    check("mid.rf_we_before", rf_we, 1);
    rst_n = 0;
    #1 check("mid.rf_we", rf_we, 0);
    check("mid.rf_wdata", rf_wdata, 0);
    check("mid.rf_waddr", rf_waddr, 0);
    check("mid.conflict_cnt", conflict_cnt, 0);
    step(); step();
    rst_n = 1;
    step();
    check("mid.no_write_after", rf_we, 0);
    step();

    // Continuous contention: starvation or aging promotion of requester 0
    req0_valid = 1; req0_addr = 3'd7; req0_data = 16'h7777;
    req1_valid = 1;
    for (int i = 0; i < 6; i++) begin
      req1_addr = 3'(i + 1); req1_data = 16'(16'h1000 + i);
      #1;
`ifdef WB_ARB_AGING_EN
      check("age.req0_ready", req0_ready, (i == STARVE_LIMIT) ? 1 : 0);
`else
      check("starve.req0_ready", req0_ready, 0);
`endif
      step();
    end

    // Saturation of the contention counter
    for (int i = 0; i < 260; i++) begin
      req1_addr = 3'(i % 7 + 1); req1_data = 16'(i);
      step();
    end
    check("sat.conflict_cnt", conflict_cnt, 255);
    req0_valid = 0; req1_valid = 0;
    step(); step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Two-requester arbiter for the single 16-bit register-file write port in the RISC datapath.
  - Requester 0 is the ALU result path.
  - Requester 1 is the memory-load path.
- Drives the select of the 16-bit 2:1 writeback mux (select=1 picks input1 = requester 1) and issues registered write-enable, address and data to the register file.
- Valid/ready handshake per requester, stall support, and a contention counter.

Parameters:
- DATA_W, 16, width of the writeback data.
- ADDR_W, 3, register-address width (8 registers).
- STARVE_LIMIT, 4, wait cycles before requester 0 is promoted (aging feature only); legal range 1..15.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- stall  in  1  pipeline freeze; blocks all acceptances.
- req0_valid  in  1  requester 0 has a write pending.
- req0_addr  in  ADDR_W  destination register of requester 0.
- req0_data  in  DATA_W  write data of requester 0.
- req0_ready  out  1  requester 0 accepted this cycle (combinational).
- req1_valid  in  1  requester 1 has a write pending.
- req1_addr  in  ADDR_W  destination register of requester 1.
- req1_data  in  DATA_W  write data of requester 1.
- req1_ready  out  1  requester 1 accepted this cycle (combinational).
- mux_sel  out  1  registered writeback mux select; 1 = requester 1, 0 = requester 0.
- rf_we  out  1  registered register-file write enable.
- rf_waddr  out  ADDR_W  registered write address.
- rf_wdata  out  DATA_W  registered write data.
- conflict_cnt  out  8  saturating count of cycles with both requests valid and stall low.

Behaviour:
- Reset (async, rst_n=0) clears all outputs and internal state:
  - mux_sel=0, rf_we=0, rf_waddr=0, rf_wdata=0, conflict_cnt=0.
  - Wait counter cleared; FSM to IDLE.
  - Readies read 0 while in reset.
  - Reset asserted mid-transfer discards the pending registered write; no write is issued after reset release.
- Grant rule (combinational, evaluated every cycle):
  - stall=1: no grant, both readies 0.
  - Only one request valid: that requester is granted.
  - Both valid: requester 1 is granted (fixed priority), except as modified by the optional feature.
  - reqN_ready = grant to N. A transfer occurs when reqN_valid and reqN_ready are both high on a rising edge.
- Latency: 1 cycle. On the edge after an accepted transfer:
  - rf_we=1, rf_waddr and rf_wdata take the granted requester's values.
  - mux_sel takes the granted index.
- Cycles with no transfer:
  - rf_we=0.
  - rf_waddr, rf_wdata and mux_sel hold their previous values.
  - rf_we is never asserted for two different sources in one cycle.
- Register 0 is hardwired zero:
  - A request with addr=0 is accepted (ready=1) and consumed.
  - It produces rf_we=0 next cycle; rf_waddr, rf_wdata and mux_sel are still updated.
- Same-address collision (both valid, equal addr): only the winner is accepted. The loser stays pending and is written on a later cycle, so the last write wins in grant order.
- FSM states:
  - IDLE: no transfer last cycle.
  - WRITE: transfer last cycle.
  - HOLD: stall asserted last cycle.
  - Transitions each edge:
    - stall=1 goes to HOLD.
    - A transfer goes to WRITE.
    - Otherwise go to IDLE.
  - State is informational for debug. Outputs are defined by the rules above.
- conflict_cnt:
  - Increments by 1 on each edge with req0_valid, req1_valid and !stall all high.
  - Saturates at 255. Cleared only by reset.
- Requesters must hold valid, addr and data stable until accepted. The arbiter does not check this.

Optional Feature:
- Macro: WB_ARB_AGING_EN.
- Defined:
  - A 4-bit wait counter increments on each edge where req0_valid=1, req0 is not granted, and stall=0.
  - When the counter reaches STARVE_LIMIT, requester 0 wins the next contended arbitration over requester 1.
  - The counter clears to 0 on a req0 transfer, or when req0_valid=0.
  - The counter holds during stall.
- Undefined: strict fixed priority applies. Requester 0 can starve indefinitely; no counter logic is synthesized.

Test Plan:
- Single request: req0 valid, addr=3, data=0x1234, stall=0 -> req0_ready=1 same cycle; next cycle rf_we=1, rf_waddr=3, rf_wdata=0x1234, mux_sel=0.
- Contention: both valid, req0 addr=2 data=0xAAAA, req1 addr=5 data=0x5555 -> req1 accepted first (mux_sel=1, rf_wdata=0x5555), req0 accepted the following cycle; conflict_cnt=1.
- Stall: both valid, stall=1 for 3 cycles -> readies 0, rf_we=0, outputs hold, conflict_cnt unchanged; on release, req1 is written first.
- Register zero: req1 valid, addr=0, data=0xFFFF -> req1_ready=1; next cycle rf_we=0, rf_wdata=0xFFFF.
- Reset mid-operation: pull rst_n low the cycle after an acceptance -> rf_we=0 immediately, all outputs 0, no write after release.
- Aging (WB_ARB_AGING_EN defined, STARVE_LIMIT=4): both valid continuously -> req1 granted for 4 cycles, req0 granted on the 5th; without the macro, req0 is never granted.
